// File: rtl/mips_isa_pkg.sv
// rtl/mips_isa_pkg.sv - shared MIPS opcode, op_sel and encoder FSM encodings
package mips_isa_pkg;

    // Primary opcode field values, shared with the control decoder
    localparam logic [5:0] R_TYPE      = 6'h00;
    localparam logic [5:0] I_TYPE_ADDI = 6'h08;
    localparam logic [5:0] I_TYPE_LUI  = 6'h0F;
    localparam logic [5:0] I_TYPE_ORI  = 6'h0D;
    localparam logic [5:0] I_TYPE_ANDI = 6'h0C;

    // Loader op_sel encodings; 5..7 are illegal and encode as NOP
    localparam logic [2:0] OP_SEL_R_TYPE = 3'd0;
    localparam logic [2:0] OP_SEL_ADDI   = 3'd1;
    localparam logic [2:0] OP_SEL_LUI    = 3'd2;
    localparam logic [2:0] OP_SEL_ORI    = 3'd3;
    localparam logic [2:0] OP_SEL_ANDI   = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } enc_state_e;

endpackage

// File: rtl/mips_instr_pack.sv
// rtl/mips_instr_pack.sv - combinational field-to-instruction-word packer
module mips_instr_pack
    import mips_isa_pkg::*;
(
    input  logic [2:0]  op_sel,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [4:0]  shamt,
    input  logic [5:0]  funct,
    input  logic [15:0] imm,
    output logic [31:0] word,
    output logic        illegal
);

    // Select the field layout for the op class; unknown classes become a NOP
    always_comb begin
        word    = 32'h0000_0000;
        illegal = 1'b0;
        case (op_sel)
            OP_SEL_R_TYPE: word = {R_TYPE, rs, rt, rd, shamt, funct};
            OP_SEL_ADDI:   word = {I_TYPE_ADDI, rs, rt, imm};
            OP_SEL_LUI:    word = {I_TYPE_LUI, 5'd0, rt, imm};
            OP_SEL_ORI:    word = {I_TYPE_ORI, rs, rt, imm};
            OP_SEL_ANDI:   word = {I_TYPE_ANDI, rs, rt, imm};
            default:       illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/mips_instr_encoder.sv
// rtl/mips_instr_encoder.sv - streams encoded MIPS words into instruction memory
module mips_instr_encoder
    import mips_isa_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int ADDR_STEP = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] base_addr_i,
    input  logic [ADDR_W-1:0] count_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [2:0]        op_sel_i,
    input  logic [4:0]        rs_i,
    input  logic [4:0]        rt_i,
    input  logic [4:0]        rd_i,
    input  logic [4:0]        shamt_i,
    input  logic [5:0]        funct_i,
    input  logic [15:0]       imm_i,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    input  logic              mem_ready_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o
);

    enc_state_e        state;
    logic [ADDR_W-1:0] next_addr;
    logic [ADDR_W-1:0] remaining;
    logic [31:0]       pack_word;
    logic              pack_illegal;
    logic              accept;
    logic              retire;

    mips_instr_pack u_pack (
        .op_sel  (op_sel_i),
        .rs      (rs_i),
        .rt      (rt_i),
        .rd      (rd_i),
        .shamt   (shamt_i),
        .funct   (funct_i),
        .imm     (imm_i),
        .word    (pack_word),
        .illegal (pack_illegal)
    );

    // The holding register can take a new word when empty or draining this cycle
    assign req_ready_o = (state == ST_LOAD) && (remaining != '0) &&
                         (!mem_we_o || mem_ready_i);
    assign accept      = req_valid_i && req_ready_o;
    assign retire      = mem_we_o && mem_ready_i;

    // Session FSM with registered status outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= ST_IDLE;
            busy_o <= 1'b0;
            done_o <= 1'b0;
            err_o  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_i) begin
                        err_o  <= 1'b0;
                        busy_o <= 1'b1;
                        if (count_i != '0) begin
                            state <= ST_LOAD;
                        end else begin
                            state  <= ST_DONE;
                            done_o <= 1'b1;
                        end
                    end
                end
                ST_LOAD: begin
                    if (accept && pack_illegal) begin
                        err_o <= 1'b1;
                    end
                    // With nothing left to accept, the word being retired is the last one
                    if (retire && (remaining == '0)) begin
                        state  <= ST_DONE;
                        done_o <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state  <= ST_IDLE;
                    busy_o <= 1'b0;
                    done_o <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Address/remaining counters and the single-entry output holding register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= 32'h0000_0000;
            next_addr   <= '0;
            remaining   <= '0;
        end else begin
            if ((state == ST_IDLE) && start_i) begin
                next_addr <= base_addr_i;
                remaining <= count_i;
            end
            if (accept) begin
                mem_we_o    <= 1'b1;
                mem_addr_o  <= next_addr;
                mem_wdata_o <= pack_word;
                next_addr   <= next_addr + ADDR_W'(ADDR_STEP);
                remaining   <= remaining - ADDR_W'(1);
            end else if (retire) begin
                mem_we_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mips_instr_encoder.sv
// tb/tb_mips_instr_encoder.sv - self-checking bench for mips_instr_encoder
module tb_mips_instr_encoder;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_i;
    logic [31:0] base_addr_i;
    logic [31:0] count_i;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [2:0]  op_sel_i;
    logic [4:0]  rs_i, rt_i, rd_i, shamt_i;
    logic [5:0]  funct_i;
    logic [15:0] imm_i;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        mem_ready_i;
    logic        busy_o, done_o, err_o;

    logic        b_start, b_valid, b_ready, b_we, b_mem_ready, b_busy, b_done, b_err;
    logic [7:0]  b_base, b_count, b_addr;
    logic [15:0] b_imm;
    logic [31:0] b_wdata;

    int checks = 0;
    int errors = 0;

    logic [63:0] exp_q[$];
    logic [31:0] model_base;
    int          model_idx;
    bit          chk_en = 1'b0;
    bit          prev_hold = 1'b0;
    logic [31:0] prev_addr, prev_wdata;
    time         t_first, t_last;

    always #5 clk = ~clk;

    mips_instr_encoder #(.ADDR_W(32), .ADDR_STEP(4)) u_dut (
        .clk(clk), .reset(reset), .start_i(start_i), .base_addr_i(base_addr_i),
        .count_i(count_i), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .op_sel_i(op_sel_i), .rs_i(rs_i), .rt_i(rt_i), .rd_i(rd_i),
        .shamt_i(shamt_i), .funct_i(funct_i), .imm_i(imm_i),
        .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_ready_i(mem_ready_i), .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
    );

    mips_instr_encoder #(.ADDR_W(8), .ADDR_STEP(4)) u_dut8 (
        .clk(clk), .reset(reset), .start_i(b_start), .base_addr_i(b_base),
        .count_i(b_count), .req_valid_i(b_valid), .req_ready_o(b_ready),
        .op_sel_i(3'd1), .rs_i(5'd0), .rt_i(5'd1), .rd_i(5'd0),
        .shamt_i(5'd0), .funct_i(6'd0), .imm_i(b_imm),
        .mem_we_o(b_we), .mem_addr_o(b_addr), .mem_wdata_o(b_wdata),
        .mem_ready_i(b_mem_ready), .busy_o(b_busy), .done_o(b_done), .err_o(b_err)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Instruction word from the ISA field layout, built arithmetically
    function automatic logic [31:0] model_encode(input int op, input int rs, input int rt,
                                                 input int rd, input int sh, input int fn,
                                                 input int imm);
        int opc_tab[5] = '{0, 8, 15, 13, 12};
        int v;
        if (op > 4) return 32'h0;
        if (op == 0)
            v = rs * (1 << 21) + rt * (1 << 16) + rd * (1 << 11) + sh * (1 << 6) + fn;
        else
            v = opc_tab[op] * (1 << 26) + ((op == 2) ? 0 : rs) * (1 << 21)
                + rt * (1 << 16) + imm;
        return 32'(v);
    endfunction

    // Every cycle: retired writes must match the scoreboard; held writes must stay put
    always @(negedge clk) begin
        if (!chk_en) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                check("hold_we", mem_we_o, 1'b1);
                check("hold_addr", mem_addr_o, prev_addr);
                check("hold_wdata", mem_wdata_o, prev_wdata);
            end
            if (mem_we_o && !mem_ready_i)
                check("ready_low_when_stalled", req_ready_o, 1'b0);
            if (!busy_o)
                check("ready_low_when_idle", req_ready_o, 1'b0);
            if (mem_we_o && mem_ready_i) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_write", 1'b1, 1'b0);
                end else begin
                    check("write_addr", mem_addr_o, {32'h0, exp_q[0][63:32]});
                    check("write_data", mem_wdata_o, {32'h0, exp_q[0][31:0]});
                    void'(exp_q.pop_front());
                end
            end
            prev_hold  = mem_we_o && !mem_ready_i;
            prev_addr  = mem_addr_o;
            prev_wdata = mem_wdata_o;
        end
    end

    task automatic start_session(input logic [31:0] base, input logic [31:0] count);
        base_addr_i = base;
        count_i     = count;
        start_i     = 1'b1;
        model_base  = base;
        model_idx   = 0;
        @(posedge clk); #1;
        start_i     = 1'b0;
    endtask

    task automatic send(input int op, input int rs, input int rt, input int rd,
                        input int sh, input int fn, input int imm);
        bit ok = 1'b0;
        op_sel_i = 3'(op); rs_i = 5'(rs); rt_i = 5'(rt); rd_i = 5'(rd);
        shamt_i = 5'(sh); funct_i = 6'(fn); imm_i = 16'(imm);
        req_valid_i = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (req_ready_o) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            check("accept_timeout", 1'b0, 1'b1);
        end else begin
            @(posedge clk);
            t_last = $time;
            exp_q.push_back({model_base + 32'(model_idx * 4),
                             model_encode(op, rs, rt, rd, sh, fn, imm)});
            model_idx++;
        end
        #1;
        req_valid_i = 1'b0;
    endtask

    task automatic wait_done();
        bit ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done_o) begin ok = 1'b1; break; end
        end
        check("done_seen", ok, 1'b1);
        check("busy_during_done", busy_o, 1'b1);
        @(negedge clk);
        check("done_one_cycle", done_o, 1'b0);
        check("busy_falls", busy_o, 1'b0);
        check("scoreboard_drained", exp_q.size(), 0);
        @(posedge clk); #1;
    endtask

    task automatic b_send(input logic [15:0] imm, input logic [7:0] exp_addr);
        bit ok = 1'b0;
        b_imm = imm;
        b_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (b_ready) begin ok = 1'b1; break; end
        end
        check("w8_accept", ok, 1'b1);
        @(posedge clk); #1;
        b_valid = 1'b0;
        check("w8_we", b_we, 1'b1);
        check("w8_addr", b_addr, exp_addr);
        check("w8_wdata", b_wdata, {16'h2001, imm});
    endtask

    initial begin
        reset = 1'b0; start_i = 1'b0; base_addr_i = '0; count_i = '0;
        req_valid_i = 1'b0; op_sel_i = '0; rs_i = '0; rt_i = '0; rd_i = '0;
        shamt_i = '0; funct_i = '0; imm_i = '0; mem_ready_i = 1'b1;
        b_start = 1'b0; b_valid = 1'b0; b_base = '0; b_count = '0; b_imm = '0;
        b_mem_ready = 1'b1;
        model_base = '0; model_idx = 0;

        // Pin the model against literal encodings
        check("model_addi", model_encode(1, 0, 8, 0, 0, 0, 5), 32'h2008_0005);
        check("model_r", model_encode(0, 8, 9, 10, 0, 32, 0), 32'h0109_5020);
        check("model_lui", model_encode(2, 7, 1, 0, 0, 0, 16'h1001), 32'h3C01_1001);
        check("model_ori", model_encode(3, 1, 1, 0, 0, 0, 16'h24), 32'h3421_0024);
        check("model_andi", model_encode(4, 8, 9, 0, 0, 0, 16'hFF), 32'h3109_00FF);
        check("model_illegal", model_encode(6, 3, 4, 5, 6, 7, 16'h1234), 32'h0);

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_we", mem_we_o, 1'b0);
        check("rst_addr", mem_addr_o, 32'h0);
        check("rst_wdata", mem_wdata_o, 32'h0);
        check("rst_busy", busy_o, 1'b0);
        check("rst_done", done_o, 1'b0);
        check("rst_err", err_o, 1'b0);
        check("rst_ready", req_ready_o, 1'b0);
        @(posedge clk); #1;
        reset  = 1'b1;
        chk_en = 1'b1;
        @(posedge clk); #1;

        // Single ADDI
        start_session(32'h0040_0000, 32'd1);
        send(1, 0, 8, 0, 0, 0, 5);
        check("t1_we", mem_we_o, 1'b1);
        check("t1_addr", mem_addr_o, 32'h0040_0000);
        check("t1_wdata", mem_wdata_o, 32'h2008_0005);
        wait_done();

        // Four back-to-back words
        start_session(32'h0000_1000, 32'd4);
        send(0, 8, 9, 10, 0, 32'h20, 0);
        t_first = t_last;
        check("t2_w0", mem_wdata_o, 32'h0109_5020);
        check("t2_a0", mem_addr_o, 32'h0000_1000);
        send(2, 7, 1, 0, 0, 0, 16'h1001);
        check("t2_w1", mem_wdata_o, 32'h3C01_1001);
        check("t2_a1", mem_addr_o, 32'h0000_1004);
        send(3, 1, 1, 0, 0, 0, 16'h24);
        check("t2_w2", mem_wdata_o, 32'h3421_0024);
        check("t2_a2", mem_addr_o, 32'h0000_1008);
        send(4, 8, 9, 0, 0, 0, 16'hFF);
        check("t2_w3", mem_wdata_o, 32'h3109_00FF);
        check("t2_a3", mem_addr_o, 32'h0000_100C);
        check("t2_throughput", 64'(t_last - t_first), 64'd30);
        wait_done();

        // Backpressure for three cycles mid-stream
        start_session(32'h0000_2000, 32'd4);
        send(1, 1, 2, 0, 0, 0, 16'h0011);
        mem_ready_i = 1'b0;
        fork
            begin
                send(1, 1, 2, 0, 0, 0, 16'h0022);
                send(1, 1, 2, 0, 0, 0, 16'h0033);
                send(1, 1, 2, 0, 0, 0, 16'h0044);
            end
            begin
                repeat (3) begin
                    @(negedge clk);
                    check("t3_ready_held_low", req_ready_o, 1'b0);
                    check("t3_word_held", mem_wdata_o, 32'h2022_0011);
                end
                @(posedge clk); #1;
                mem_ready_i = 1'b1;
            end
        join
        wait_done();

        // Illegal op_sel writes a NOP and sets sticky err
        start_session(32'h0000_3000, 32'd2);
        send(6, 3, 4, 5, 6, 7, 16'h1234);
        check("t4_nop", mem_wdata_o, 32'h0);
        send(1, 0, 8, 0, 0, 0, 5);
        check("t4_err_set", err_o, 1'b1);
        wait_done();
        check("t4_err_sticky", err_o, 1'b1);

        // Empty session: done without writes; start clears err
        start_session(32'h0000_5000, 32'd0);
        @(negedge clk);
        check("t5_done_pulse", done_o, 1'b1);
        check("t5_no_write", mem_we_o, 1'b0);
        check("t5_err_cleared", err_o, 1'b0);
        @(negedge clk);
        check("t5_done_drop", done_o, 1'b0);
        check("t5_idle", busy_o, 1'b0);
        @(posedge clk); #1;

        // 8-bit address wrap
        b_base = 8'hFC; b_count = 8'd2; b_start = 1'b1;
        @(posedge clk); #1;
        b_start = 1'b0;
        b_send(16'h0001, 8'hFC);
        b_send(16'h0002, 8'h00);
        begin
            bit ok = 1'b0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (b_done) begin ok = 1'b1; break; end
            end
            check("w8_done", ok, 1'b1);
        end
        @(posedge clk); #1;

        // Reset while a write is pending
        start_session(32'h0000_6000, 32'd3);
        mem_ready_i = 1'b0;
        send(1, 0, 1, 0, 0, 0, 16'h0099);
        chk_en = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        check("t6_we", mem_we_o, 1'b0);
        check("t6_addr", mem_addr_o, 32'h0);
        check("t6_wdata", mem_wdata_o, 32'h0);
        check("t6_busy", busy_o, 1'b0);
        check("t6_done", done_o, 1'b0);
        check("t6_ready", req_ready_o, 1'b0);
        @(posedge clk); #1;
        reset = 1'b1;
        exp_q.delete();
        mem_ready_i = 1'b1;
        @(posedge clk); #1;
        chk_en = 1'b1;
        start_session(32'h0000_7000, 32'd1);
        send(4, 2, 3, 0, 0, 0, 16'h00F0);
        check("t6_fresh_addr", mem_addr_o, 32'h0000_7000);
        check("t6_fresh_wdata", mem_wdata_o, 32'h3043_00F0);
        wait_done();

        check("final_queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
